serial_subtractor: RTL and testbench

//  Bit-serial subtractor computing d = a - b - bi, LSB first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 10 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 109 ++++++++++
 tb/tb_serial_subtractor.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Purely combinational 1-bit full subtractor: d = a - b - bi, bo = borrow out.
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor d = a - b - bi, LSB first, one bit per clock,
// built around a single full-subtractor cell and a registered borrow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, d_reg;
  logic             brw_reg, bo_reg, ovf_reg;
  logic [CW-1:0]    cnt_reg;
  logic             cell_d, cell_bo;
  logic             last_bit;
  logic             accept;

  full_subtractor_1bit u_cell (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .bi (brw_reg),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (last_bit) state_next = S_DONE;
      end
      S_DONE: begin
        // A start seen in DONE chains straight into the next operation.
        if (start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      d_reg     <= '0;
      brw_reg   <= 1'b0;
      bo_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg   <= a;
        b_reg   <= b;
        brw_reg <= bi;
        d_reg   <= '0;
        bo_reg  <= 1'b0;
        ovf_reg <= 1'b0;
        cnt_reg <= '0;
      end else if (state_reg == S_RUN) begin
        d_reg   <= {cell_d, d_reg[WIDTH-1:1]};
        a_reg   <= a_reg >> 1;
        b_reg   <= b_reg >> 1;
        brw_reg <= cell_bo;
        if (last_bit) begin
          // On the last step a_reg[0]/b_reg[0] hold the operand sign bits.
          bo_reg  <= cell_bo;
          ovf_reg <= (a_reg[0] ^ b_reg[0]) & (cell_d ^ a_reg[0]);
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign busy = (state_reg == S_RUN);
  assign done = (state_reg == S_DONE);
  assign d    = d_reg;
  assign bo   = bo_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (WIDTH=4) with immediate assertions.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bi;
  logic         busy, done, bo, ovf;
  logic [W-1:0] d;

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle right after acceptance; ends in the done cycle.
  task automatic wait_result(input string tag, input logic [W-1:0] ed,
                             input logic ebo, input logic eovf);
    check({tag, ".busy0"}, busy, 1);
    check({tag, ".done0"}, done, 0);
    repeat (W - 1) begin
      tick();
      check({tag, ".busy"}, busy, 1);
    end
    tick();
    check({tag, ".done"}, done, 1);
    check({tag, ".busy_off"}, busy, 0);
    check({tag, ".d"}, d, ed);
    check({tag, ".bo"}, bo, ebo);
    check({tag, ".ovf"}, ovf, eovf);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tbi, input logic [W-1:0] ed, input logic ebo,
                        input logic eovf);
    a = ta; b = tb_; bi = tbi; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~ta; b = ~tb_; bi = ~tbi;
    wait_result(tag, ed, ebo, eovf);
  endtask

  initial begin
    int sa, sb, sr, ur;
    logic [W-1:0] ra, rb;
    logic rbi;
    logic [W-1:0] ed;
    logic ebo, eovf;

    rst_n = 1'b0; start = 1'b1; a = 4'd9; b = 4'd3; bi = 1'b0;
    tick();
    tick();
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.d", d, 0);
    check("reset.bo", bo, 0);
    check("reset.ovf", ovf, 0);
    rst_n = 1'b1; start = 1'b0;
    tick();

    // -7 - 3 and 3 - (-7) both leave the 4-bit signed range.
    run_op("sub_9_3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);
    tick();
    run_op("sub_3_9", 4'd3, 4'd9, 1'b0, 4'd10, 1'b1, 1'b1);
    tick();
    run_op("sub_0_0_bi", 4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0);
    tick();
    run_op("sub_m8_1", 4'b1000, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1);
    tick();
    run_op("sub_7_m1", 4'd7, 4'b1111, 1'b0, 4'd8, 1'b1, 1'b1);
    tick();
    run_op("sub_eq", 4'd11, 4'd11, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();

    // start held through RUN while operands wander: 6 - 2 = 4 from captured values
    a = 4'd6; b = 4'd2; bi = 1'b0; start = 1'b1;
    tick();
    for (int i = 0; i < W - 1; i++) begin
      check("hold.busy", busy, 1);
      a = 4'(i + 12); b = 4'(i + 1); bi = 1'b1;
      tick();
    end
    check("hold.busy_last", busy, 1);
    start = 1'b0;
    tick();
    check("hold.done", done, 1);
    check("hold.d", d, 4);
    check("hold.bo", bo, 0);
    tick();
    check("hold.single_done", done, 0);
    check("hold.idle_busy", busy, 0);

    // back-to-back: second start issued in the done cycle
    run_op("b2b_first", 4'd12, 4'd5, 1'b0, 4'd7, 1'b0, 1'b1);
    run_op("b2b_second", 4'd2, 4'd7, 1'b1, 4'd10, 1'b1, 1'b0);
    tick();

    // abort: reset during the 2nd RUN cycle
    a = 4'd7; b = 4'd0; bi = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("abort.busy1", busy, 1);
    tick();
    check("abort.partial_d", d, 8);
    rst_n = 1'b0;
    tick();
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.d", d, 0);
    check("abort.bo", bo, 0);
    check("abort.ovf", ovf, 0);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("abort.no_done", done, 0);
    end
    run_op("after_abort", 4'd5, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();

    for (int n = 0; n < 1000; n++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rbi = 1'($urandom_range(0, 1));
      ur  = int'(ra) - int'(rb) - int'(rbi);
      ed  = 4'(ur);
      ebo = (ur < 0);
      sa  = (ra > 4'd7) ? int'(ra) - 16 : int'(ra);
      sb  = (rb > 4'd7) ? int'(rb) - 16 : int'(rb);
      sr  = sa - sb - int'(rbi);
      eovf = (sr < -8) || (sr > 7);
      run_op($sformatf("rnd%0d_%0d_%0d_%0d", n, ra, rb, rbi), ra, rb, rbi, ed, ebo, eovf);
      if (n % 3 == 0) tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
